// File: rtl/cpu_clock_gate.sv
// cpu_clock_gate: turns synchronised slow-clock rising edges into CPU clock-enable pulses, with reset sequencing and halt/step control
module cpu_clock_gate #(
  parameter int SYNC_STAGES = 2,
  parameter int RESET_EDGES = 4,
  parameter int CYCLE_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clk_in,
  input  logic                   halt,
  input  logic                   resume,
  output logic                   cpu_ce,
  output logic                   cpu_rst_n,
  output logic                   halted,
  output logic [CYCLE_CNT_W-1:0] cycle_count
);
  localparam int EW = RESET_EDGES > 0 ? $clog2(RESET_EDGES + 1) : 1;
  localparam logic [EW-1:0] EDGES = EW'(RESET_EDGES);
  typedef enum logic [1:0] {S_RESET, S_RUN, S_HALTED, S_STEP} state_t;
  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_prev_q, resume_prev_q;
  logic [EW-1:0]          edge_q, edge_d;
  logic                   cpu_ce_q, cpu_ce_d, cpu_rst_n_q, halted_q;
  logic [CYCLE_CNT_W-1:0] cycle_count_q, cycle_count_d;
  logic                   rise, resume_rise;
  assign rise        = sync_q[SYNC_STAGES-1] & ~sync_prev_q;
  assign resume_rise = resume & ~resume_prev_q;
  assign cpu_ce      = cpu_ce_q;
  assign cpu_rst_n   = cpu_rst_n_q;
  assign halted      = halted_q;
  assign cycle_count = cycle_count_q;
  always_comb begin
    state_d       = state_q;
    edge_d        = edge_q;
    cpu_ce_d      = 1'b0;
    cycle_count_d = cycle_count_q;
    case (state_q)
      S_RESET: begin
        if (RESET_EDGES == 0) state_d = S_RUN;
        else if (rise) begin
          edge_d = edge_q + EW'(1);
          if (edge_d == EDGES) state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (rise && halt) state_d = S_HALTED;
        else if (rise) begin
          cpu_ce_d      = 1'b1;
          cycle_count_d = cycle_count_q + CYCLE_CNT_W'(1);
        end
      end
      S_HALTED: state_d = resume_rise ? S_STEP : S_HALTED;
      S_STEP: begin
        if (rise) begin
          cpu_ce_d      = 1'b1;
          cycle_count_d = cycle_count_q + CYCLE_CNT_W'(1);
          state_d       = S_RUN;
        end
      end
      default: state_d = S_RESET;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q        <= '0;
      sync_prev_q   <= 1'b0;
      resume_prev_q <= 1'b0;
      state_q       <= S_RESET;
      edge_q        <= '0;
      cpu_ce_q      <= 1'b0;
      cpu_rst_n_q   <= 1'b0;
      halted_q      <= 1'b0;
      cycle_count_q <= '0;
    end else begin
      sync_q        <= {sync_q[SYNC_STAGES-2:0], clk_in};
      sync_prev_q   <= sync_q[SYNC_STAGES-1];
      resume_prev_q <= resume;
      state_q       <= state_d;
      edge_q        <= edge_d;
      cpu_ce_q      <= cpu_ce_d;
      cpu_rst_n_q   <= state_d != S_RESET;
      halted_q      <= state_d == S_HALTED;
      cycle_count_q <= cycle_count_d;
    end
  end
endmodule

// File: tb/tb_cpu_clock_gate.sv
// tb_cpu_clock_gate: scoreboard bench driving slow-clock periods and checking pulses, counts and halt/reset outputs
module tb_cpu_clock_gate;
  localparam int SYNC = 2;
  logic clk = 1'b0, rst_n = 1'b0, clk_in = 1'b0, halt = 1'b0, resume = 1'b0;
  logic cpu_ce, cpu_rst_n, halted;
  logic [15:0] cycle_count;
  logic w_ce, w_rst_n, w_halted;
  logic [3:0] w_count;
  int checks = 0, errors = 0, res_left = 0, w_pulses = 0;
  typedef struct {string tag; bit ce; int cnt; bit hlt; bit rstn;} exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  cpu_clock_gate #(.SYNC_STAGES(SYNC), .RESET_EDGES(4), .CYCLE_CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .clk_in(clk_in), .halt(halt), .resume(resume),
    .cpu_ce(cpu_ce), .cpu_rst_n(cpu_rst_n), .halted(halted), .cycle_count(cycle_count));

  cpu_clock_gate #(.SYNC_STAGES(SYNC), .RESET_EDGES(0), .CYCLE_CNT_W(4)) dut_w (
    .clk(clk), .rst_n(rst_n), .clk_in(clk_in), .halt(halt), .resume(resume),
    .cpu_ce(w_ce), .cpu_rst_n(w_rst_n), .halted(w_halted), .cycle_count(w_count));

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (res_left > 0) begin
      res_left--;
      if (res_left == 0) resume = 1'b0;
    end
  endtask

  task automatic zeros(input string tag);
    check({tag, "_ce"}, 32'(cpu_ce), 0);
    check({tag, "_rstn"}, 32'(cpu_rst_n), 0);
    check({tag, "_halted"}, 32'(halted), 0);
    check({tag, "_count"}, 32'(cycle_count), 0);
    check({tag, "_w_rstn"}, 32'(w_rst_n), 0);
    check({tag, "_w_count"}, 32'(w_count), 0);
  endtask

  task automatic pulse_resume(input string tag);
    resume = 1'b1;
    res_left = 1;
    tick();
    check({tag, "_halted"}, 32'(halted), 0);
  endtask

  task automatic period(input string tag, input bit e_ce, input int e_cnt, input bit e_hlt,
                        input bit e_rstn, input int hi = 10, input int len = 20,
                        input int res_at = 0, input int res_len = 0);
    exp_t e;
    int n = 0;
    int first = 0;
    sb.push_back('{tag, e_ce, e_cnt, e_hlt, e_rstn});
    tick();
    clk_in = 1'b1;
    for (int i = 1; i <= len; i++) begin
      tick();
      if (cpu_ce) begin
        n++;
        if (first == 0) first = i;
      end
      if (w_ce) w_pulses++;
      if (i == hi) clk_in = 1'b0;
      if (i == res_at) begin
        resume = 1'b1;
        res_left = res_len;
      end
    end
    e = sb.pop_front();
    check({e.tag, "_pulses"}, 32'(n), 32'(e.ce));
    if (e.ce) check({e.tag, "_latency"}, 32'(first), SYNC + 1);
    check({e.tag, "_count"}, 32'(cycle_count), 32'(e.cnt));
    check({e.tag, "_halted"}, 32'(halted), 32'(e.hlt));
    check({e.tag, "_rstn"}, 32'(cpu_rst_n), 32'(e.rstn));
  endtask

  initial begin
    repeat (3) tick();
    zeros("por");
    rst_n = 1'b1;
    tick();
    check("w_rstn_release", 32'(w_rst_n), 1);
    check("rstn_hold", 32'(cpu_rst_n), 0);
    for (int k = 1; k <= 3; k++) period($sformatf("rst%0d", k), 0, 0, 0, 0);
    period("rst4", 0, 0, 0, 1);
    period("first", 1, 1, 0, 1);
    for (int k = 0; k < 12; k++) period($sformatf("run%0d", k), 1, 2 + k, 0, 1);
    check("wrap_w_count", 32'(w_count), 1);
    check("wrap_w_pulses", 32'(w_pulses), 17);
    period("glitch", 1, 14, 0, 1, 100, 120);
    halt = 1'b1;
    for (int k = 0; k < 4; k++) period($sformatf("hold%0d", k), 0, 14, 1, 1);
    pulse_resume("res1");
    period("step", 1, 15, 0, 1);
    period("rehalt", 0, 15, 1, 1);
    period("sim", 0, 15, 0, 1, 10, 20, 2, 1);
    period("sim_step", 1, 16, 0, 1);
    period("sim_halt", 0, 16, 1, 1);
    period("held", 0, 16, 0, 1, 10, 20, 2, 50);
    period("held_step", 1, 17, 0, 1);
    period("held_halt", 0, 17, 1, 1);
    period("held_single", 0, 17, 1, 1);
    halt = 1'b0;
    pulse_resume("res2");
    period("resume_run", 1, 18, 0, 1);
    period("run_b", 1, 19, 0, 1);
    rst_n = 1'b0;
    #1;
    zeros("async");
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check("w_rstn_rerelease", 32'(w_rst_n), 1);
    check("rstn_rehold", 32'(cpu_rst_n), 0);
    for (int k = 1; k <= 3; k++) period($sformatf("rerst%0d", k), 0, 0, 0, 0);
    period("rerst4", 0, 0, 0, 1);
    period("after_rst", 1, 1, 0, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cpu_clock_gate.md
Name: cpu_clock_gate

Overview:
Downstream consumer of the clock module's slow clk_out. Synchronises it into the fast system clock domain and converts each rising edge into a one-cycle CPU clock-enable pulse. Sequences the CPU's power-on reset over a fixed number of slow edges. Handles HLT (halt) and resume so the 8-bit CPU core runs fully synchronous on clk gated by cpu_ce.

Parameters:
SYNC_STAGES, 2, flops in the clk_in synchroniser chain (legal values ≥2)
RESET_EDGES, 4, slow-clock rising edges during which cpu_rst_n is held low after rst_n release (0 allowed)
CYCLE_CNT_W, 16, width of cycle_count

Ports:
clk  input  1  system clock; the same fast clock that drives the clock module
rst_n  input  1  asynchronous, active-low reset
clk_in  input  1  slow clock from the clock module's clk_out; asynchronous to clk
halt  input  1  CPU HLT request, level, synchronous to clk
resume  input  1  resume request, level, synchronous to clk; internally edge-detected
cpu_ce  output  1  registered one-cycle clock-enable pulse to the CPU
cpu_rst_n  output  1  registered active-low reset to the CPU
halted  output  1  high while in HALTED
cycle_count  output  CYCLE_CNT_W  count of issued cpu_ce pulses

Behaviour:
- Reset is asynchronous and active-low. While rst_n=0: sync chain=0, edge-detect history=0, resume history=0, cpu_ce=0, cpu_rst_n=0, halted=0, cycle_count=0, edge counter=0, state=S_RESET.
- Assertion of rst_n mid-operation immediately forces all of the above, regardless of state.
- Synchroniser: clk_in passes through SYNC_STAGES flops. rise = sync_out & ~sync_prev.
- Latency: clk_in sampled high at clk edge k gives cpu_ce high for exactly the cycle after edge k+SYNC_STAGES.
- A clk_in held high yields one pulse only. Pulses shorter than one clk period may be missed; this is acceptable.
- resume_rise = resume & ~resume_prev. It is registered every cycle in all states.
- S_RESET: cpu_rst_n=0, cpu_ce never asserted. Each rise increments the edge counter. On the rise that makes the counter equal RESET_EDGES, go to S_RUN. cpu_rst_n goes to 1 on the same edge as the transition, and that rise produces no cpu_ce.
- RESET_EDGES=0: go to S_RUN on the first clk edge after rst_n release, with no rise needed.
- S_RUN, on rise with halt=0: cpu_ce=1 next cycle and cycle_count+1.
- S_RUN, on rise with halt=1: no cpu_ce, go to S_HALTED, halted=1.
- halt is examined only on rise cycles.
- S_HALTED: cpu_ce=0. Rises are ignored. On resume_rise go to S_STEP and set halted=0.
- Simultaneous resume_rise and rise in S_HALTED: the transition occurs and that rise is consumed without a pulse.
- S_STEP: the next rise issues cpu_ce unconditionally (halt ignored) with cycle_count+1, then go to S_RUN. This lets the CPU advance past its HLT instruction.
- resume_rise in S_RUN, S_STEP or S_RESET is ignored.
- cycle_count wraps from 2^CYCLE_CNT_W−1 to 0 with no flag.
- cpu_ce is never high for two consecutive clk cycles.
- cpu_ce is never high while cpu_rst_n=0 or halted=1.
- State encoding: S_RESET, S_RUN, S_HALTED, S_STEP. Unused encodings return to S_RESET.

Test Plan:
- Reset sequencing (defaults, clk_in period 20 clk, rst_n released at t0): cpu_rst_n=0 through rises 1–3 with no cpu_ce; cpu_rst_n=1 after rise 4; first cpu_ce on rise 5, exactly SYNC_STAGES+1 clk edges after clk_in is sampled high; cycle_count=1.
- Steady run, 10 clk_in periods after sequencing: exactly 10 single-cycle cpu_ce pulses, 20 clk apart; cycle_count=10; halted=0 throughout.
- Halt/resume: halt=1 held before rise N → no pulse on rise N or on the 3 rises that follow, halted=1. Pulse resume for 1 cycle, keeping halt=1 → next rise gives exactly one cpu_ce and halted=0. The rise after that gives no pulse and re-enters S_HALTED.
- Resume on the same cycle as a rise while in S_HALTED: no pulse on that rise; pulse on the following rise. Resume held high for 50 clk counts as a single request.
- Wrap and glitch, CYCLE_CNT_W=4: 17 pulses → cycle_count=1. clk_in held high for 100 clk → one pulse.
- Async reset mid-run (rst_n=0 for 3 clk between edges, while cpu_ce=0): all outputs 0 immediately; after release, the RESET_EDGES sequence repeats. With RESET_EDGES=0, cpu_rst_n=1 one clk after release.
